// File: rtl/numa_rx_parser_pkg.sv
// Shared constants for the IP-NUMA receive parser: frame field values, byte
// offsets after the SFD, master-queue tag codes and the parser state encoding.
package numa_rx_parser_pkg;

  localparam int PHY_W = 9;
  localparam int MST_W = 18;

  localparam logic [15:0] DEF_UDP_PORT  = 16'h3776;
  localparam logic [5:0]  DEF_MIN_BYTES = 6'd50;

  localparam logic [7:0]  SFD            = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VIHL      = 8'h45;
  localparam logic [7:0]  IPPROTO_UDP    = 8'd17;

  // Byte indices counted from the first byte after the SFD
  localparam logic [5:0] IDX_MAC_LAST = 6'd5;
  localparam logic [5:0] IDX_ETYPE    = 6'd12;
  localparam logic [5:0] IDX_VIHL     = 6'd14;
  localparam logic [5:0] IDX_PROTO    = 6'd23;
  localparam logic [5:0] IDX_DST_IP   = 6'd30;
  localparam logic [5:0] IDX_DST_PORT = 6'd36;
  localparam logic [5:0] IDX_OFFSET   = 6'd42;
  localparam logic [5:0] IDX_WDATA    = 6'd46;

  localparam logic [1:0] TAG_START = 2'b10;
  localparam logic [1:0] TAG_MID   = 2'b00;
  localparam logic [1:0] TAG_END   = 2'b01;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HDR,
    ST_PAY,
    ST_EMIT,
    ST_DRAIN,
    ST_DROP
  } state_t;

  function automatic logic [MST_W-1:0] mst_word(input logic [1:0] tag,
                                                input logic [15:0] data);
    return {tag, data};
  endfunction

endpackage

// File: rtl/numa_rx_parser_if.sv
// Byte stream from the rx PHY FIFO and word stream into the master write queue.
// The parser uses the master modport; the FIFO/queue side uses slave.
interface numa_rx_parser_if;
  import numa_rx_parser_pkg::*;

  logic [PHY_W-1:0] phy_dout;
  logic             phy_empty;
  logic             phy_rd_en;
  logic [MST_W-1:0] mst_din;
  logic             mst_full;
  logic             mst_wr_en;

  modport master (
    input  phy_dout,
    input  phy_empty,
    input  mst_full,
    output phy_rd_en,
    output mst_din,
    output mst_wr_en
  );

  modport slave (
    output phy_dout,
    output phy_empty,
    output mst_full,
    input  phy_rd_en,
    input  mst_din,
    input  mst_wr_en
  );

endinterface

// File: rtl/numa_rx_parser.sv
// IP-NUMA receive parser: filters IPv4/UDP remote-write frames addressed to us
// and turns each into a 4-word write record for the master write queue.
module numa_rx_parser
  import numa_rx_parser_pkg::*;
#(
  parameter logic [15:0] UDP_PORT  = DEF_UDP_PORT,
  parameter logic [5:0]  MIN_BYTES = DEF_MIN_BYTES
) (
  input  logic                   pcie_clk,
  input  logic                   sys_rst_n,
  numa_rx_parser_if.master       rx,
  input  logic [31:0]            if_v4addr,
  input  logic [47:0]            if_macaddr,
  input  logic [47:0]            mem0_paddr,
  output logic [15:0]            rx_frame_cnt,
  output logic [15:0]            rx_drop_cnt
);

  state_t           state;
  state_t           next_state;
  logic             rd_vld;
  logic [PHY_W-1:0] skid;
  logic             skid_vld;
  logic [5:0]       idx;
  logic             ucast_ok;
  logic             bcast_ok;
  logic [31:0]      offset;
  logic [31:0]      wdata;
  logic [1:0]       wcnt;

  logic             byte_vld;
  logic             dv;
  logic [7:0]       data;
  logic [7:0]       mac_byte;
  logic             uc_next;
  logic             bc_next;
  logic             field_ok;
  logic [31:0]      emit_addr;
  logic [MST_W-1:0] emit_word;
  logic             drop_evt;
  logic             frame_evt;

  logic unused_ok;
  assign unused_ok = ^{mem0_paddr[47:32], offset[1:0]};

  // A byte caught in flight while entering EMIT is replayed from the skid
  // register on the first cycle after EMIT, ahead of any new FIFO data.
  always_comb begin
    byte_vld = skid_vld || (rd_vld && (state != ST_EMIT));
    dv       = skid_vld ? skid[8]   : rx.phy_dout[8];
    data     = skid_vld ? skid[7:0] : rx.phy_dout[7:0];
  end

  // Destination MAC must match either our address or broadcast across all six
  // bytes, so both candidates are tracked separately and resolved at byte 5.
  always_comb begin
    mac_byte = 8'h00;
    case (idx)
      6'd0:    mac_byte = if_macaddr[47:40];
      6'd1:    mac_byte = if_macaddr[39:32];
      6'd2:    mac_byte = if_macaddr[31:24];
      6'd3:    mac_byte = if_macaddr[23:16];
      6'd4:    mac_byte = if_macaddr[15:8];
      6'd5:    mac_byte = if_macaddr[7:0];
      default: mac_byte = 8'h00;
    endcase
    uc_next  = ucast_ok && (data == mac_byte);
    bc_next  = bcast_ok && (data == 8'hFF);
    field_ok = 1'b1;
    case (idx)
      IDX_MAC_LAST:          field_ok = uc_next || bc_next;
      IDX_ETYPE:             field_ok = (data == ETHERTYPE_IPV4[15:8]);
      IDX_ETYPE + 6'd1:      field_ok = (data == ETHERTYPE_IPV4[7:0]);
      IDX_VIHL:              field_ok = (data == IPV4_VIHL);
      IDX_PROTO:             field_ok = (data == IPPROTO_UDP);
      IDX_DST_IP:            field_ok = (data == if_v4addr[31:24]);
      IDX_DST_IP + 6'd1:     field_ok = (data == if_v4addr[23:16]);
      IDX_DST_IP + 6'd2:     field_ok = (data == if_v4addr[15:8]);
      IDX_DST_IP + 6'd3:     field_ok = (data == if_v4addr[7:0]);
      IDX_DST_PORT:          field_ok = (data == UDP_PORT[15:8]);
      IDX_DST_PORT + 6'd1:   field_ok = (data == UDP_PORT[7:0]);
      default:               field_ok = 1'b1;
    endcase
  end

  always_comb begin
    emit_addr = mem0_paddr[31:0] + {offset[31:2], 2'b00};
    case (wcnt)
      2'd0:    emit_word = mst_word(TAG_START, emit_addr[31:16]);
      2'd1:    emit_word = mst_word(TAG_MID,   emit_addr[15:0]);
      2'd2:    emit_word = mst_word(TAG_MID,   wdata[31:16]);
      default: emit_word = mst_word(TAG_END,   wdata[15:0]);
    endcase
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_HUNT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    drop_evt      = 1'b0;
    frame_evt     = 1'b0;
    rx.phy_rd_en  = !rx.phy_empty && (state != ST_EMIT);
    rx.mst_wr_en  = 1'b0;
    rx.mst_din    = '0;
    case (state)
      ST_HUNT: begin
        if (byte_vld && dv && (data == SFD)) begin
          next_state = ST_HDR;
        end
      end
      ST_HDR, ST_PAY: begin
        if (byte_vld) begin
          if (!dv) begin
            next_state = ST_HUNT;
            drop_evt   = (idx < MIN_BYTES);
          end else if (!field_ok) begin
            next_state = ST_DROP;
            drop_evt   = 1'b1;
          end else if (idx == MIN_BYTES - 6'd1) begin
            next_state = ST_EMIT;
          end else if (idx == IDX_OFFSET - 6'd1) begin
            next_state = ST_PAY;
          end
        end
      end
      ST_EMIT: begin
        rx.mst_din   = emit_word;
        rx.mst_wr_en = !rx.mst_full;
        if (!rx.mst_full && (wcnt == 2'd3)) begin
          next_state = ST_DRAIN;
          frame_evt  = 1'b1;
        end
      end
      ST_DRAIN, ST_DROP: begin
        if (byte_vld && !dv) begin
          next_state = ST_HUNT;
        end
      end
      default: next_state = ST_HUNT;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_vld   <= 1'b0;
      skid     <= '0;
      skid_vld <= 1'b0;
      idx      <= '0;
      ucast_ok <= 1'b0;
      bcast_ok <= 1'b0;
      offset   <= '0;
      wdata    <= '0;
      wcnt     <= '0;
    end else begin
      rd_vld <= rx.phy_rd_en;
      if (state == ST_EMIT) begin
        if (rd_vld) begin
          skid     <= rx.phy_dout;
          skid_vld <= 1'b1;
        end
      end else if (skid_vld) begin
        skid_vld <= 1'b0;
      end
      if (state == ST_HUNT) begin
        idx      <= '0;
        ucast_ok <= 1'b1;
        bcast_ok <= 1'b1;
        wcnt     <= '0;
      end else if (((state == ST_HDR) || (state == ST_PAY)) && byte_vld && dv) begin
        idx <= idx + 6'd1;
        if (idx <= IDX_MAC_LAST) begin
          ucast_ok <= uc_next;
          bcast_ok <= bc_next;
        end
        if ((idx >= IDX_OFFSET) && (idx < IDX_WDATA)) begin
          offset <= {offset[23:0], data};
        end else if ((idx >= IDX_WDATA) && (idx < IDX_WDATA + 6'd4)) begin
          wdata <= {wdata[23:0], data};
        end
      end
      if ((state == ST_EMIT) && !rx.mst_full) begin
        wcnt <= wcnt + 2'd1;
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_frame_cnt <= '0;
      rx_drop_cnt  <= '0;
    end else begin
      if (frame_evt) begin
        rx_frame_cnt <= rx_frame_cnt + 16'd1;
      end
      if (drop_evt) begin
        rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
    end
  end

endmodule
